// File: rtl/alu_pkg.sv
// alu_seq shared definitions: opcodes, FSM states
// and the op-class helper.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_ROL  = 4'd8;
  localparam logic [3:0] OP_ROR  = 4'd9;
  localparam logic [3:0] OP_SLT  = 4'd10;
  localparam logic [3:0] OP_SLTU = 4'd11;
  localparam logic [3:0] OP_MUL  = 4'd12;
  localparam logic [3:0] OP_MULH = 4'd13;
  localparam logic [3:0] OP_DIVU = 4'd14;
  localparam logic [3:0] OP_REMU = 4'd15;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Ops 12..15 run on the iterative engine.
  function automatic logic is_multicycle(
    input logic [3:0] op
  );
    return (op & 4'b1100) == 4'b1100;
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider,
// one step per clock, WIDTH steps per operation.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             carry
);

  localparam int CW = $clog2(WIDTH) + 1;

  // p holds {hi, lo}: product halves for mul,
  // {remainder, quotient} for div.
  logic [2*WIDTH-1:0] p_q;
  logic [2*WIDTH-1:0] p_nx;
  logic [WIDTH-1:0]   d_q;
  logic [1:0]         mode_q;
  logic               dz_q;
  logic [CW-1:0]      cnt_q;

  logic [WIDTH:0]     r_sh;
  logic [WIDTH:0]     acc;
  logic [WIDTH-1:0]   diff;
  logic               ge;

  // One multiply or divide step on the current state.
  always_comb begin
    r_sh = p_q[2*WIDTH-1:WIDTH-1];
    ge   = r_sh >= {1'b0, d_q};
    diff = r_sh[WIDTH-1:0] - d_q;
    acc  = {1'b0, p_q[2*WIDTH-1:WIDTH]}
         + {1'b0, d_q};
    p_nx = p_q;
    if (mode_q[1]) begin
      if (ge) begin
        p_nx = {diff, p_q[WIDTH-2:0], 1'b1};
      end else begin
        p_nx = {r_sh[WIDTH-1:0],
                p_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      if (p_q[0]) begin
        p_nx = {acc, p_q[WIDTH-1:1]};
      end else begin
        p_nx = {1'b0, p_q[2*WIDTH-1:1]};
      end
    end
  end

  // The final step's outcome is presented while the
  // last count is still pending, so the top can
  // register it on that same edge.
  assign done   = (cnt_q == CW'(1));
  assign result = mode_q[0]
                ? p_nx[2*WIDTH-1:WIDTH]
                : p_nx[WIDTH-1:0];
  assign carry  = (mode_q == 2'b00)
                && (|p_nx[2*WIDTH-1:WIDTH]);
  assign overflow = mode_q[1] && dz_q;

  // Operand load on start, then iterate to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q    <= '0;
      d_q    <= '0;
      mode_q <= '0;
      dz_q   <= 1'b0;
      cnt_q  <= '0;
    end else if (start) begin
      p_q    <= {{WIDTH{1'b0}},
                 (mode[1] ? a : b)};
      d_q    <= mode[1] ? b : a;
      mode_q <= mode;
      dz_q   <= (b == '0);
      cnt_q  <= CW'(WIDTH);
    end else if (cnt_q != '0) begin
      p_q   <= p_nx;
      cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered, valid/ready ALU with single-cycle ops
// and an iterative mul/div engine.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             overflow,
  output logic             carry,
  output logic             zero,
  output logic             negative,
  output logic             busy
);

  localparam int SW = $clog2(WIDTH);

  state_t state_q;
  state_t state_nx;

  logic             accept;
  logic             start;
  logic             ld_sc;
  logic             eng_done;
  logic [WIDTH-1:0] eng_res;
  logic             eng_ovf;
  logic             eng_carry;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   dif;
  logic [SW-1:0]    sh;
  logic [SW-1:0]    rl;
  logic             sat;
  logic [WIDTH-1:0] sc_y;
  logic             sc_ovf;
  logic             sc_carry;
  logic [WIDTH-1:0] ld_y;
  logic             ld_ovf;
  logic             ld_carry;

  assign busy     = (state_q == ST_BUSY);
  assign in_ready = !busy
                  && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign start    = accept && is_multicycle(op);
  assign ld_sc    = accept && !is_multicycle(op);

  alu_muldiv_iter #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .mode     (op[1:0]),
    .done     (eng_done),
    .result   (eng_res),
    .overflow (eng_ovf),
    .carry    (eng_carry)
  );

  // Single-cycle datapath; shifts saturate, rotates
  // wrap modulo WIDTH.
  always_comb begin
    sum = {1'b0, a} + {1'b0, b};
    dif = {1'b0, a} - {1'b0, b};
    sh  = b[SW-1:0];
    rl  = '0 - sh;
    sat = |b[WIDTH-1:SW];
    sc_y     = '0;
    sc_ovf   = 1'b0;
    sc_carry = 1'b0;
    case (op)
      OP_ADD: begin
        sc_y     = sum[WIDTH-1:0];
        sc_carry = sum[WIDTH];
        sc_ovf   = (a[WIDTH-1] == b[WIDTH-1])
                 && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_y     = dif[WIDTH-1:0];
        sc_carry = dif[WIDTH];
        sc_ovf   = (a[WIDTH-1] != b[WIDTH-1])
                 && (dif[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: sc_y = a & b;
      OP_OR:  sc_y = a | b;
      OP_XOR: sc_y = a ^ b;
      OP_SLL: begin
        if (sat) sc_y = '0;
        else     sc_y = a << sh;
      end
      OP_SRL: begin
        if (sat) sc_y = '0;
        else     sc_y = a >> sh;
      end
      OP_SRA: begin
        if (sat) sc_y = {WIDTH{a[WIDTH-1]}};
        else     sc_y = $signed(a) >>> sh;
      end
      OP_ROL: sc_y = WIDTH'({a, a} >> rl);
      OP_ROR: sc_y = WIDTH'({a, a} >> sh);
      OP_SLT: begin
        sc_y = {{(WIDTH-1){1'b0}},
                $signed(a) < $signed(b)};
      end
      OP_SLTU: begin
        sc_y = {{(WIDTH-1){1'b0}}, a < b};
      end
      default: ;
    endcase
  end

  assign ld_y     = eng_done ? eng_res   : sc_y;
  assign ld_ovf   = eng_done ? eng_ovf   : sc_ovf;
  assign ld_carry = eng_done ? eng_carry : sc_carry;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_nx;
  end

  // FSM next state: idle until a multi-cycle
  // accept, busy until the engine finishes.
  always_comb begin
    state_nx = state_q;
    unique case (state_q)
      ST_IDLE: if (start)    state_nx = ST_BUSY;
      ST_BUSY: if (eng_done) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Output register with its own valid; holds
  // steady under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      y         <= '0;
      overflow  <= 1'b0;
      carry     <= 1'b0;
      zero      <= 1'b0;
      negative  <= 1'b0;
    end else if (ld_sc || eng_done) begin
      out_valid <= 1'b1;
      y         <= ld_y;
      overflow  <= ld_ovf;
      carry     <= ld_carry;
      zero      <= (ld_y == '0);
      negative  <= ld_y[WIDTH-1];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=8: expected
// results queued at accept, checked at transfer.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic [3:0] op = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] y;
  logic       overflow;
  logic       carry;
  logic       zero;
  logic       negative;
  logic       busy;

  int total = 0;
  int bad   = 0;
  logic rand_bp = 1'b0;

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] y;
    logic [3:0] f;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  alu_seq #(
    .WIDTH (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .overflow  (overflow),
    .carry     (carry),
    .zero      (zero),
    .negative  (negative),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic exp_t model(
    input logic [3:0] o,
    input logic [7:0] x,
    input logic [7:0] z
  );
    exp_t e;
    logic [8:0]  s;
    logic [15:0] p;
    logic        v;
    logic        c;
    logic [7:0]  r;
    int          k;
    v = 1'b0;
    c = 1'b0;
    r = '0;
    k = int'(z[2:0]);
    p = 16'(x) * 16'(z);
    case (o)
      4'd0: begin
        s = {1'b0, x} + {1'b0, z};
        r = s[7:0];
        c = s[8];
        v = (x[7] == z[7]) && (r[7] != x[7]);
      end
      4'd1: begin
        s = {1'b0, x} - {1'b0, z};
        r = s[7:0];
        c = s[8];
        v = (x[7] != z[7]) && (r[7] != x[7]);
      end
      4'd2: r = x & z;
      4'd3: r = x | z;
      4'd4: r = x ^ z;
      4'd5: r = (z >= 8) ? 8'h00 : (x << z);
      4'd6: r = (z >= 8) ? 8'h00 : (x >> z);
      4'd7: begin
        if (z >= 8) r = {8{x[7]}};
        else        r = $signed(x) >>> z;
      end
      4'd8: begin
        for (int i = 0; i < 8; i++)
          r[(i + k) % 8] = x[i];
      end
      4'd9: begin
        for (int i = 0; i < 8; i++)
          r[i] = x[(i + k) % 8];
      end
      4'd10: r = {7'd0, $signed(x) < $signed(z)};
      4'd11: r = {7'd0, x < z};
      4'd12: begin
        r = p[7:0];
        c = (p[15:8] != 8'h00);
      end
      4'd13: r = p[15:8];
      4'd14: begin
        if (z == 0) begin r = 8'hFF; v = 1'b1; end
        else r = x / z;
      end
      default: begin
        if (z == 0) begin r = x; v = 1'b1; end
        else r = x % z;
      end
    endcase
    e.op = o;
    e.y  = r;
    e.f  = {v, c, (r == 8'h00), r[7]};
    return e;
  endfunction

  // Entry and exit at posedge+1; in_valid is left
  // low so back-to-back calls still run at full rate.
  task automatic send(
    input  logic [3:0] o,
    input  logic [7:0] x,
    input  logic [7:0] z,
    output int         stalls
  );
    in_valid = 1'b1;
    op = o;
    a  = x;
    b  = z;
    stalls = 0;
    @(negedge clk);
    while (!in_ready && stalls < 100) begin
      stalls++;
      @(negedge clk);
    end
    if (!in_ready) chk("accept_timeout",
                       32'(in_ready), 32'd1);
    @(posedge clk);
    if (in_ready) sb.push_back(model(o, x, z));
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_left", 32'(sb.size()), 32'd0);
  endtask

  // Transfer monitor: pops one expectation per
  // output handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("spurious_out", 32'(out_valid), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk($sformatf("y_op%0d", mon_e.op),
            32'(y), 32'(mon_e.y));
        chk($sformatf("flags_op%0d", mon_e.op),
            32'({overflow, carry, zero, negative}),
            32'(mon_e.f));
      end
    end
  end

  // Random consumer backpressure when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_bp)
        out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    int st;
    int st2;
    int lat;
    logic [3:0] ro;
    logic [7:0] ra;
    logic [7:0] rb;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_flags",
        32'({overflow, carry, zero, negative}),
        32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(4'd0, 8'h7F, 8'h01, st);
    wait_valid(lat);
    chk("add_latency", 32'(lat), 32'd0);
    drain();

    send(4'd1, 8'h00, 8'h01, st);
    send(4'd0, 8'hFF, 8'h01, st2);
    chk("b2b_stall_sub", 32'(st), 32'd0);
    chk("b2b_stall_add", 32'(st2), 32'd0);
    drain();

    send(4'd12, 8'h10, 8'h10, st);
    chk("mul_busy", 32'(busy), 32'd1);
    chk("mul_in_ready", 32'(in_ready), 32'd0);
    wait_valid(lat);
    chk("mul_latency", 32'(lat), 32'd8);
    send(4'd13, 8'h10, 8'h10, st);
    send(4'd14, 8'hC8, 8'h07, st);
    wait_valid(lat);
    chk("divu_latency", 32'(lat), 32'd8);
    send(4'd15, 8'hC8, 8'h07, st);
    send(4'd14, 8'h55, 8'h00, st);
    wait_valid(lat);
    chk("div0_latency", 32'(lat), 32'd8);
    send(4'd15, 8'h55, 8'h00, st);
    drain();

    out_ready = 1'b0;
    send(4'd7, 8'h80, 8'h09, st);
    repeat (5) begin
      @(negedge clk);
      chk("bp_y", 32'(y), 32'hFF);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(4'd8, 8'h81, 8'h09, st);
    drain();

    send(4'd14, 8'hC8, 8'h07, st);
    void'(sb.pop_back());
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_y", 32'(y), 32'd0);
    chk("abort_flags",
        32'({overflow, carry, zero, negative}),
        32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    send(4'd0, 8'h02, 8'h03, st);
    drain();

    send(4'd1, 8'h80, 8'h01, st);
    send(4'd5, 8'h01, 8'h08, st);
    send(4'd6, 8'h80, 8'h03, st);
    send(4'd9, 8'h01, 8'h01, st);
    send(4'd10, 8'h80, 8'h01, st);
    send(4'd11, 8'h80, 8'h01, st);
    send(4'd2, 8'hF0, 8'h3C, st);
    send(4'd3, 8'hF0, 8'h0C, st);
    send(4'd4, 8'hFF, 8'hFF, st);
    send(4'd7, 8'h90, 8'h02, st);
    drain();

    rand_bp = 1'b1;
    for (int i = 0; i < 40; i++) begin
      ro = 4'($urandom_range(0, 15));
      ra = 8'($urandom);
      rb = 8'($urandom);
      if (i % 5 == 0) rb = 8'($urandom_range(0, 9));
      send(ro, ra, rb, st);
    end
    rand_bp = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
